// File: rtl/decoder_intra_luma4x4.sv
// decoder_intra_luma4x4 -- reconstructs one 4x4 luma block as clip(pred + residual).
//
// Sequence: start (in IDLE) latches mode, neighbours and availability flags,
// then PRED (1 cycle) builds the 16-entry prediction, STREAM accepts 16 raster
// residual beats, and DONE pulses done_luma4x4 for one cycle.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   start           one-cycle request, honoured only in IDLE
//   mode            0=vertical 1=horizontal 2=DC 3=diag-down-left, others DC
//   top_pix         t[0..7], t[i] at bits [i*BIT_DEPTH +: BIT_DEPTH]
//   left_pix        l[0..3], same packing
//   top_avail, left_avail  neighbour availability
//   busy            high from the cycle after start until done_luma4x4 falls
//   res_valid/res_ready/res_data  signed residual stream, raster order
//   pix_valid/pix_data/pix_idx    reconstructed pixel, one cycle after its beat
//   done_luma4x4    one-cycle end-of-block pulse
//   mode_err        requested mode was unusable and DC was substituted
//
// Build option: define INTRA_DDL_EN to enable mode 3 (diagonal down-left).
// Without it, mode 3 falls back to DC with mode_err set.
module decoder_intra_luma4x4 #(
  parameter int BIT_DEPTH = 8,
  parameter int RES_WIDTH = BIT_DEPTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             mode,
  input  logic [8*BIT_DEPTH-1:0] top_pix,
  input  logic [4*BIT_DEPTH-1:0] left_pix,
  input  logic                   top_avail,
  input  logic                   left_avail,
  output logic                   busy,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [RES_WIDTH-1:0]   res_data,
  output logic                   pix_valid,
  output logic [BIT_DEPTH-1:0]   pix_data,
  output logic [3:0]             pix_idx,
  output logic                   done_luma4x4,
  output logic                   mode_err
);

  localparam int SW = RES_WIDTH + 1;
`ifdef INTRA_DDL_EN
  localparam int NT = 8;
`else
  localparam int NT = 4;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRED, S_STREAM, S_DONE} state_t;
  typedef enum logic [1:0] {PM_VERT, PM_HORZ, PM_DC, PM_DDL} pmode_t;

  state_t                 state_q, state_d;
  pmode_t                 pm_q, pm_sel;
  logic                   err_sel;
  logic [BIT_DEPTH-1:0]   t_q [NT];
  logic [BIT_DEPTH-1:0]   l_q [4];
  logic                   top_q, left_q;
  logic [BIT_DEPTH-1:0]   pred_q [16];
  logic [BIT_DEPTH-1:0]   pred_d [16];
  logic [BIT_DEPTH+1:0]   sum_t, sum_l, dc_t, dc_l;
  logic [BIT_DEPTH+2:0]   sum_all;
  logic [BIT_DEPTH-1:0]   dc_val;
  logic [4:0]             cnt_q;
  logic                   beat;
  logic signed [SW-1:0]   recon_sum;
  logic [BIT_DEPTH-1:0]   recon_clip;

`ifdef INTRA_DDL_EN
  logic [BIT_DEPTH+1:0]   ddl_sum [7];
  logic [BIT_DEPTH-1:0]   ddl_val [7];
`else
  logic                   unused_top;
  assign unused_top = ^top_pix[8*BIT_DEPTH-1:4*BIT_DEPTH];
`endif

  // Effective prediction mode and fallback flag, resolved at start time.
  always_comb begin
    pm_sel  = PM_DC;
    err_sel = 1'b0;
    case (mode)
      4'd0: if (top_avail) pm_sel = PM_VERT; else err_sel = 1'b1;
      4'd1: if (left_avail) pm_sel = PM_HORZ; else err_sel = 1'b1;
      4'd2: pm_sel = PM_DC;
`ifdef INTRA_DDL_EN
      4'd3: if (top_avail) pm_sel = PM_DDL; else err_sel = 1'b1;
`endif
      default: err_sel = 1'b1;
    endcase
  end

  // Two-process FSM: register here, next state and handshake outputs below.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    res_ready    = 1'b0;
    done_luma4x4 = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_PRED;
      S_PRED: begin
        busy    = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        // cnt_q[4] marks the drain cycle after beat 15, where the last pixel
        // is on the output register and no further beats are taken.
        res_ready = ~cnt_q[4];
        if (cnt_q[4]) state_d = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done_luma4x4 = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign beat = res_valid & res_ready;

  // DC value from the latched neighbours.
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum_t = sum_t + {2'b00, t_q[i]};
      sum_l = sum_l + {2'b00, l_q[i]};
    end
    sum_all = {1'b0, sum_t} + {1'b0, sum_l} + (BIT_DEPTH+3)'(4);
    dc_t    = sum_t + (BIT_DEPTH+2)'(2);
    dc_l    = sum_l + (BIT_DEPTH+2)'(2);
    if (top_q && left_q) dc_val = sum_all[BIT_DEPTH+2:3];
    else if (top_q)      dc_val = dc_t[BIT_DEPTH+1:2];
    else if (left_q)     dc_val = dc_l[BIT_DEPTH+1:2];
    else                 dc_val = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  end

`ifdef INTRA_DDL_EN
  // Diagonal down-left depends only on x+y, so 7 filter taps cover the block.
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      ddl_sum[i] = {2'b00, t_q[i]} + {1'b0, t_q[i+1], 1'b0} + {2'b00, t_q[i+2]}
                 + (BIT_DEPTH+2)'(2);
    end
    ddl_sum[6] = {2'b00, t_q[6]} + {1'b0, t_q[7], 1'b0} + {2'b00, t_q[7]}
               + (BIT_DEPTH+2)'(2);
    for (int unsigned i = 0; i < 7; i++) ddl_val[i] = ddl_sum[i][BIT_DEPTH+1:2];
  end
`endif

  always_comb begin
    for (int unsigned y = 0; y < 4; y++) begin
      for (int unsigned x = 0; x < 4; x++) begin
        case (pm_q)
          PM_VERT: pred_d[4*y+x] = t_q[x];
          PM_HORZ: pred_d[4*y+x] = l_q[y];
`ifdef INTRA_DDL_EN
          PM_DDL:  pred_d[4*y+x] = ddl_val[x+y];
`endif
          default: pred_d[4*y+x] = dc_val;
        endcase
      end
    end
  end

  // Reconstruction: sign bit clear plus any bit at or above BIT_DEPTH set
  // means overflow past the pixel maximum.
  always_comb begin
    recon_sum = $signed({{(SW-BIT_DEPTH){1'b0}}, pred_q[cnt_q[3:0]]})
              + SW'($signed(res_data));
    if (recon_sum[SW-1])                 recon_clip = '0;
    else if (|recon_sum[SW-2:BIT_DEPTH]) recon_clip = '1;
    else                                 recon_clip = recon_sum[BIT_DEPTH-1:0];
  end

  // Datapath registers without reset: only meaningful after a start.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      for (int unsigned i = 0; i < NT; i++) t_q[i] <= top_pix[i*BIT_DEPTH +: BIT_DEPTH];
      for (int unsigned i = 0; i < 4; i++)  l_q[i] <= left_pix[i*BIT_DEPTH +: BIT_DEPTH];
      top_q  <= top_avail;
      left_q <= left_avail;
      pm_q   <= pm_sel;
    end
    if (state_q == S_PRED) begin
      for (int unsigned i = 0; i < 16; i++) pred_q[i] <= pred_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_idx   <= '0;
      mode_err  <= 1'b0;
    end else begin
      pix_valid <= beat;
      if (beat) begin
        pix_data <= recon_clip;
        pix_idx  <= cnt_q[3:0];
        cnt_q    <= cnt_q + 5'd1;
      end
      if (state_q == S_IDLE && start) begin
        cnt_q    <= '0;
        mode_err <= err_sel;
      end
    end
  end

endmodule

// File: tb/tb_decoder_intra_luma4x4.sv
module tb_decoder_intra_luma4x4;

  localparam int BD = 8;
  localparam int RW = BD + 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [3:0]    mode;
  logic [8*BD-1:0] top_pix;
  logic [4*BD-1:0] left_pix;
  logic          top_avail, left_avail;
  logic          busy, res_valid, res_ready;
  logic [RW-1:0] res_data;
  logic          pix_valid;
  logic [BD-1:0] pix_data;
  logic [3:0]    pix_idx;
  logic          done_luma4x4, mode_err;

  decoder_intra_luma4x4 #(.BIT_DEPTH(BD), .RES_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .top_pix(top_pix), .left_pix(left_pix),
    .top_avail(top_avail), .left_avail(left_avail), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_idx(pix_idx),
    .done_luma4x4(done_luma4x4), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int data; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int exp_lat = 0;
  bit exp_err = 1'b0;
  bit prev_valid = 1'b0;
  int last_idx = -1;

  int t_a[8];
  int l_a[4];
  int res_a[16];
  int pred_a[16];
  bit model_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference prediction straight from the block's rules.
  function automatic void model(input int m, input bit ta, input bit la);
    int eff, st, sl, dc, i;
    eff = 2;
    model_err = 1'b0;
    if (m == 0) begin
      if (ta) eff = 0; else model_err = 1'b1;
    end else if (m == 1) begin
      if (la) eff = 1; else model_err = 1'b1;
    end else if (m == 2) begin
      eff = 2;
    end else if (m == 3) begin
`ifdef INTRA_DDL_EN
      if (ta) eff = 3; else model_err = 1'b1;
`else
      model_err = 1'b1;
`endif
    end else begin
      model_err = 1'b1;
    end
    st = t_a[0] + t_a[1] + t_a[2] + t_a[3];
    sl = l_a[0] + l_a[1] + l_a[2] + l_a[3];
    if (ta && la) dc = (st + sl + 4) / 8;
    else if (ta)  dc = (st + 2) / 4;
    else if (la)  dc = (sl + 2) / 4;
    else          dc = 1 << (BD - 1);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        i = x + y;
        case (eff)
          0: pred_a[4*y+x] = t_a[x];
          1: pred_a[4*y+x] = l_a[y];
          3: pred_a[4*y+x] = (i < 6) ? (t_a[i] + 2*t_a[i+1] + t_a[i+2] + 2) / 4
                                     : (t_a[6] + 3*t_a[7] + 2) / 4;
          default: pred_a[4*y+x] = dc;
        endcase
      end
    end
  endfunction

  function automatic int clipv(input int s);
    if (s < 0) return 0;
    if (s > (1 << BD) - 1) return (1 << BD) - 1;
    return s;
  endfunction

  // Monitor: pops the scoreboard on every presented pixel, checks block end.
  always @(negedge clk) begin
    exp_t e;
    if (reset && start && !busy) start_cyc = cyc;
    if (pix_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got idx=%0d data=%0d, expected no pixel", pix_idx, pix_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(pix_idx) != e.idx || int'(pix_data) != e.data) begin
          errors++;
          $display("FAIL pixel: got idx=%0d data=%0d, expected idx=%0d data=%0d",
                   pix_idx, pix_data, e.idx, e.data);
        end
      end
      last_idx = int'(pix_idx);
    end
    if (done_luma4x4) begin
      done_cnt++;
      checks++;
      if (mode_err !== exp_err) begin
        errors++;
        $display("FAIL mode_err: got %0b, expected %0b", mode_err, exp_err);
      end
      checks++;
      if (exp_q.size() != 0 || !prev_valid || last_idx != 15) begin
        errors++;
        $display("FAIL done_order: pending=%0d prev_valid=%0b last_idx=%0d, expected 0/1/15",
                 exp_q.size(), prev_valid, last_idx);
      end
      if (exp_lat != 0) begin
        checks++;
        if (cyc - start_cyc != exp_lat) begin
          errors++;
          $display("FAIL latency: got %0d cycles, expected %0d", cyc - start_cyc, exp_lat);
        end
      end
    end
    prev_valid = pix_valid;
  end

  // gap: 0 = res_valid held high, 1 = toggling, 2 = random
  // rst_after > 0: pull reset after that many beats and expect no done pulse
  task automatic run_block(input int m, input bit ta, input bit la, input int gap, input int rst_after);
    int k, n, d0;
    bit v;
    model(m, ta, la);
    d0 = done_cnt;
    @(posedge clk); #1;
    exp_err = model_err;
    exp_lat = (gap == 0 && rst_after <= 0) ? 19 : 0;
    for (int i = 0; i < 8; i++) top_pix[i*BD +: BD] = BD'(t_a[i]);
    for (int i = 0; i < 4; i++) left_pix[i*BD +: BD] = BD'(l_a[i]);
    mode = 4'(m);
    top_avail = ta;
    left_avail = la;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs are latched at start; scramble them to expose any later sampling.
    top_pix = {$urandom, $urandom};
    left_pix = $urandom;
    mode = 4'($urandom_range(0, 15));
    top_avail = 1'($urandom_range(0, 1));
    left_avail = 1'($urandom_range(0, 1));
    k = 0;
    n = 0;
    while (k < 16 && n < 300) begin
      case (gap)
        0: v = 1'b1;
        1: v = (n % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      res_valid = v;
      res_data = RW'(res_a[k]);
      @(negedge clk);
      if (res_ready && res_valid) begin
        exp_q.push_back('{k, clipv(pred_a[k] + res_a[k])});
        k++;
      end
      @(posedge clk); #1;
      n++;
      if (rst_after > 0 && k == rst_after) break;
    end
    res_valid = 1'b0;
    if (rst_after > 0 && k == rst_after) begin
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      checks++;
      if (pix_valid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0 || done_luma4x4 !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset: got pix_valid=%0b busy=%0b res_ready=%0b done=%0b, expected all 0",
                 pix_valid, busy, res_ready, done_luma4x4);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pre_reset_pixels: %0d pixels not presented, expected 0", exp_q.size());
      end
      repeat (25) @(posedge clk);
      #1;
      checks++;
      if (done_cnt != d0) begin
        errors++;
        $display("FAIL abandoned_done: got %0d done pulses, expected 0", done_cnt - d0);
      end
      exp_q.delete();
      return;
    end
    if (k < 16) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: accepted %0d beats, expected 16", k);
    end
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL done_pulse: got %0d pulses, expected 1", done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got %0b after done, expected 0", busy);
    end
    exp_q.delete();
  endtask

  task automatic rand_pix();
    for (int i = 0; i < 8; i++) t_a[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) l_a[i] = int'($urandom_range(0, 255));
  endtask

  task automatic rand_res();
    for (int i = 0; i < 16; i++) res_a[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  initial begin
    int m;
    reset = 1'b0; start = 1'b0; mode = '0; top_pix = '0; left_pix = '0;
    top_avail = 1'b0; left_avail = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || res_ready !== 1'b0 || pix_valid !== 1'b0 || pix_data !== '0 ||
        pix_idx !== '0 || done_luma4x4 !== 1'b0 || mode_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b rdy=%0b pv=%0b pd=%0d pi=%0d done=%0b err=%0b, expected all 0",
               busy, res_ready, pix_valid, pix_data, pix_idx, done_luma4x4, mode_err);
    end
    reset = 1'b1;

    // Vertical, zero residuals, full rate.
    rand_pix();
    t_a[0] = 10; t_a[1] = 20; t_a[2] = 30; t_a[3] = 40;
    for (int i = 0; i < 16; i++) res_a[i] = 0;
    run_block(0, 1'b1, 1'b1, 0, 0);

    // DC with both neighbours, residual +3.
    for (int i = 0; i < 8; i++) t_a[i] = 100;
    for (int i = 0; i < 4; i++) l_a[i] = 50;
    for (int i = 0; i < 16; i++) res_a[i] = 3;
    run_block(2, 1'b1, 1'b1, 0, 0);

    // Horizontal clipping at both ends.
    rand_pix();
    rand_res();
    l_a[0] = 250; l_a[1] = 5;
    for (int i = 0; i < 4; i++) begin res_a[i] = 20; res_a[4+i] = -20; end
    run_block(1, 1'b0, 1'b1, 0, 0);

    // Backpressure with alternating res_valid.
    rand_pix();
    rand_res();
    run_block(int'($urandom_range(0, 2)), 1'b1, 1'b1, 1, 0);

    // Vertical without top neighbours, neither side available.
    rand_pix();
    for (int i = 0; i < 16; i++) res_a[i] = 0;
    run_block(0, 1'b0, 1'b0, 0, 0);

    // Reset after 7 pixels, then a fresh block.
    rand_pix();
    rand_res();
    run_block(2, 1'b1, 1'b0, 0, 7);
    rand_pix();
    rand_res();
    run_block(1, 1'b1, 1'b1, 0, 0);

    // Mode 3: diagonal down-left when built in, DC fallback otherwise.
    for (int i = 0; i < 8; i++) t_a[i] = 4 * i;
    for (int i = 0; i < 4; i++) l_a[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) res_a[i] = 0;
    run_block(3, 1'b1, 1'b1, 0, 0);
    rand_pix();
    run_block(3, 1'b0, 1'b1, 0, 0);

    // Randomised blocks, random gaps, all modes.
    for (int b = 0; b < 14; b++) begin
      rand_pix();
      rand_res();
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      run_block(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_intra_luma4x4.md
Name: decoder_intra_luma4x4

Overview:
Decoder-side counterpart of the intra encoder's luma 4x4 path. It reconstructs one 4x4 luma block from three inputs: the latched prediction mode, the neighbouring pixels, and a 16-beat raster residual stream. Each output pixel is clip(pred + residual), streamed one per accepted beat. A single-cycle done_luma4x4 pulse ends each block, matching the encoder's completion flag so the decoder loop can step block by block.

Parameters:
BIT_DEPTH, 8, pixel width in bits; clip range is 0..2^BIT_DEPTH-1.
RES_WIDTH, BIT_DEPTH+1, signed residual width in two's complement.

Ports:
clk  input  1  single clock; everything is on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
start  input  1  one-cycle request; latches mode, neighbours and availability flags.
mode  input  4  0=vertical, 1=horizontal, 2=DC, 3=diag-down-left (see option), others treated as DC.
top_pix  input  8*BIT_DEPTH  t[0..7]; byte i = t[i], LSB first.
left_pix  input  4*BIT_DEPTH  l[0..3]; byte i = l[i].
top_avail  input  1  top neighbours valid.
left_avail  input  1  left neighbours valid.
busy  output  1  high from the cycle after start until done_luma4x4 deasserts.
res_valid  input  1  residual beat present.
res_ready  output  1  block accepts a residual beat.
res_data  input  RES_WIDTH  signed residual, raster order (idx = 4*y + x).
pix_valid  output  1  reconstructed pixel valid.
pix_data  output  BIT_DEPTH  reconstructed pixel.
pix_idx  output  4  raster index of pix_data.
done_luma4x4  output  1  one-cycle end-of-block pulse.
mode_err  output  1  fallback flag; valid while done_luma4x4 is high, cleared on the next start.

Behaviour:
- Reset (reset==0 at an edge): FSM goes to IDLE. busy, res_ready, pix_valid, pix_data, pix_idx, done_luma4x4 and mode_err all become 0. The residual counter clears. Reset mid-block abandons the block; no done pulse is produced.
- FSM states: IDLE -> PRED -> STREAM -> DONE -> IDLE.
- IDLE: start=1 latches all inputs and moves to PRED. start is ignored in every other state.
- PRED: exactly 1 cycle. Computes the 16-entry pred array into registers. res_ready=0.
- STREAM: res_ready=1. Each cycle with res_valid&&res_ready is a beat k (k = 0..15).
  - The cycle after beat k: pix_valid=1, pix_idx=k, pix_data=clip(pred[k]+res_data).
  - Gaps in res_valid produce pix_valid=0 in the corresponding cycles.
  - After beat 15, res_ready drops in the next cycle and the FSM moves to DONE.
- DONE: done_luma4x4=1 for one cycle. This is the cycle after the last pix_valid. The FSM then returns to IDLE and busy falls.
- Arithmetic: the sum pred+res is formed at RES_WIDTH+1 bits signed. Negative results clip to 0; results above max clip to 2^BIT_DEPTH-1.
- Vertical: pred[y][x] = t[x].
- Horizontal: pred[y][x] = l[y].
- DC:
  - Both neighbours available: (sum t[0..3] + sum l[0..3] + 4) >> 3.
  - Top only: (sum t[0..3] + 2) >> 2.
  - Left only: (sum l[0..3] + 2) >> 2.
  - Neither: 2^(BIT_DEPTH-1).
- Fallback to DC with mode_err=1 when:
  - vertical is requested and top_avail=0;
  - horizontal is requested and left_avail=0;
  - mode is 4..15.
- Minimum block time is 19 cycles from start to done_luma4x4 (PRED, 16 beats, output-register cycle, DONE).

Optional Feature:
Macro INTRA_DDL_EN.
- Defined, mode 3 is diagonal down-left:
  - pred[y][x] = (t[x+y] + 2*t[x+y+1] + t[x+y+2] + 2) >> 2 for x+y < 6.
  - pred[3][3] = (t[6] + 3*t[7] + 2) >> 2.
  - If top_avail=0, mode 3 falls back to DC with mode_err=1.
- Undefined: mode 3 is treated as invalid, giving DC with mode_err=1. No DDL adder logic is synthesised.

Test Plan:
- Vertical: t[0..3]=10,20,30,40, top_avail=1, residuals all 0, res_valid held high -> pixels in raster order are 10,20,30,40 repeated 4 times. done_luma4x4 pulses 19 cycles after start; mode_err=0.
- DC, both neighbours: t all 100, l all 50, residuals all +3 -> all 16 pixels = 78.
- Clipping, horizontal: l[0]=250, l[1]=5, residual +20 on row 0 and -20 on row 1 -> row 0 = 255, row 1 = 0.
- Backpressure: res_valid toggles 1,0,1,0 -> pix_valid follows one cycle later on beats only; pix_idx runs 0..15 with no skips. done pulses once, after pix_idx=15.
- Fallback and reset:
  - mode=0 with top_avail=0, left_avail=0 -> all pixels 128, mode_err=1 at done.
  - Second run: reset pulled low after 7 pixels -> next cycle pix_valid=0, busy=0, no done pulse. A fresh start then completes normally.
- With INTRA_DDL_EN: t[0..7]=0,4,8,...,28, mode 3 -> pred[0][0]=4, pred[3][3]=27, residuals 0.
